// File: rtl/bp_hb_cfg_sequencer_if.sv
// Configuration-bus write channel between the boot sequencer (master) and the core cfg slave.
// Carries valid/ready write handshake plus the slave's write-completion ack pulse.
interface bp_hb_cfg_sequencer_if #(
  parameter int unsigned cfg_addr_width_p = 20,
  parameter int unsigned cfg_data_width_p = 64
);
  logic                        cfg_v_o;
  logic [cfg_addr_width_p-1:0] cfg_addr_o;
  logic [cfg_data_width_p-1:0] cfg_data_o;
  logic                        cfg_ready_i;
  logic                        cfg_ack_i;

  modport master (
    output cfg_v_o, cfg_addr_o, cfg_data_o,
    input  cfg_ready_i, cfg_ack_i
  );

  modport slave (
    input  cfg_v_o, cfg_addr_o, cfg_data_o,
    output cfg_ready_i, cfg_ack_i
  );
endinterface

// File: rtl/bp_hb_cfg_sequencer.sv
// Boot-time cfg-bus sequencer: freeze, boot PC, cache enables, NoC DID, unfreeze.
// Optional per-write timeout enabled by defining BP_HB_CFG_SEQ_TIMEOUT_EN.
module bp_hb_cfg_sequencer #(
  parameter int unsigned              cfg_addr_width_p = 20,
  parameter int unsigned              cfg_data_width_p = 64,
  parameter int unsigned              paddr_width_p    = 40,
  parameter logic [paddr_width_p-1:0] boot_pc_p        = 40'h00_8000_0000,
  parameter logic [18:0]              did_p            = 19'h0,
  parameter int unsigned              timeout_cycles_p = 1024
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o,
  bp_hb_cfg_sequencer_if.master        cfg
);

  localparam int unsigned aw_lp       = cfg_addr_width_p;
  localparam int unsigned dw_lp       = cfg_data_width_p;
  localparam int unsigned idx_w_lp    = 3;
  localparam logic [2:0]  last_idx_lp = 3'd5;

  typedef enum logic [2:0] {
    e_idle,
    e_send,
    e_wait_ack,
    e_done,
    e_error
  } state_e;

  state_e                state_q, state_d;
  logic [idx_w_lp-1:0]   idx_q, idx_d;
  logic                  cfg_v_q, cfg_v_d;
  logic [aw_lp-1:0]      cfg_addr_q, cfg_addr_d;
  logic [dw_lp-1:0]      cfg_data_q, cfg_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  xfer_c;

  // Fixed write list
  function automatic logic [aw_lp-1:0] write_addr(input logic [idx_w_lp-1:0] idx);
    case (idx)
      3'd0:    write_addr = aw_lp'(20'h00008);
      3'd1:    write_addr = aw_lp'(20'h00010);
      3'd2:    write_addr = aw_lp'(20'h00018);
      3'd3:    write_addr = aw_lp'(20'h0001C);
      3'd4:    write_addr = aw_lp'(20'h00020);
      3'd5:    write_addr = aw_lp'(20'h00008);
      default: write_addr = '0;
    endcase
  endfunction

  function automatic logic [dw_lp-1:0] write_data(input logic [idx_w_lp-1:0] idx);
    case (idx)
      3'd0:    write_data = dw_lp'(1'b1);
      3'd1:    write_data = dw_lp'(boot_pc_p);
      3'd2:    write_data = dw_lp'(1'b1);
      3'd3:    write_data = dw_lp'(1'b1);
      3'd4:    write_data = dw_lp'(did_p);
      default: write_data = '0;
    endcase
  endfunction

  assign xfer_c = cfg_v_q & cfg.cfg_ready_i;

`ifdef BP_HB_CFG_SEQ_TIMEOUT_EN
  localparam int unsigned tmo_w_lp = $clog2(timeout_cycles_p + 1);

  logic [tmo_w_lp-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                error_q, error_d;
  logic                tmo_hit_c;

  assign tmo_hit_c = ((state_q == e_send) || (state_q == e_wait_ack)) &&
                     (tmo_cnt_q == tmo_w_lp'(timeout_cycles_p - 1));
`else
  localparam int unsigned unused_timeout_lp = timeout_cycles_p;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;

    case (state_q)
      e_idle, e_done, e_error: begin
        if (start_i) begin
          state_d = e_send;
          idx_d   = '0;
        end
      end
      e_send: begin
        if (xfer_c) state_d = e_wait_ack;
      end
      e_wait_ack: begin
        if (cfg.cfg_ack_i) begin
          if (idx_q == last_idx_lp) begin
            state_d = e_done;
          end else begin
            state_d = e_send;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      default: state_d = e_idle;
    endcase

`ifdef BP_HB_CFG_SEQ_TIMEOUT_EN
    if (tmo_hit_c) state_d = e_error;
`endif

    // Address/data latched once on entry to e_send, so they hold through any stall
    if ((state_d == e_send) && (state_q != e_send)) begin
      cfg_addr_d = write_addr(idx_d);
      cfg_data_d = write_data(idx_d);
    end

    cfg_v_d = (state_d == e_send);
    busy_d  = (state_d == e_send) || (state_d == e_wait_ack);
    done_d  = (state_d == e_done);
  end

`ifdef BP_HB_CFG_SEQ_TIMEOUT_EN
  // Counter restarts on every state change and only runs while a write is outstanding
  always_comb begin
    tmo_cnt_d = '0;
    error_d   = (state_d == e_error);
    if (((state_d == e_send) || (state_d == e_wait_ack)) && (state_d == state_q)) begin
      tmo_cnt_d = tmo_cnt_q + tmo_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tmo_cnt_q <= '0;
      error_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      error_q   <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= e_idle;
      idx_q      <= '0;
      cfg_v_q    <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cfg_v_q    <= cfg_v_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cfg.cfg_v_o    = cfg_v_q;
  assign cfg.cfg_addr_o = cfg_addr_q;
  assign cfg.cfg_data_o = cfg_data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: doc/bp_hb_cfg_sequencer.md
# bp_hb_cfg_sequencer

Boot-time configuration sequencer for the HammerBlade unicore BlackParrot. On a start pulse it issues a fixed, ordered list of configuration-bus writes: freeze the core, set the boot PC, enable both caches, program the memory-NoC destination ID, then unfreeze. It sits between the host shell and the core's cfg-bus slave, so bring-up never depends on host software ordering.

## Interface
- `cfg_addr_width_p`, 20, cfg-bus address width.
- `cfg_data_width_p`, 64, cfg-bus data width.
- `paddr_width_p`, 40, physical address width of the boot PC.
- `boot_pc_p`, 40'h00_8000_0000, value written to the NPC register.
- `did_p`, 19'h0, memory-NoC destination ID, used as the return-payload tag.
- `timeout_cycles_p`, 1024, per-write timeout limit. Only used when the macro in Configuration is defined.
- `clk_i`  in  1  core clock.
- `reset_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  single-cycle start request.
- `busy_o`  out  1  sequence in progress.
- `done_o`  out  1  all writes acknowledged. Held high until the next start or reset.
- `error_o`  out  1  timeout occurred. Held high until the next start or reset.
- `cfg_v_o`  out  1  write valid.
- `cfg_addr_o`  out  `cfg_addr_width_p`  write address.
- `cfg_data_o`  out  `cfg_data_width_p`  write data.
- `cfg_ready_i`  in  1  slave accepts the write. Transfer occurs when `cfg_v_o & cfg_ready_i`.
- `cfg_ack_i`  in  1  write-completion pulse from the slave.

## Operation
- Write list, indexed 0..5 by a 3-bit counter:
  - 0: 0x00008 ← 1 (freeze)
  - 1: 0x00010 ← `boot_pc_p`, zero-extended
  - 2: 0x00018 ← 1 (icache mode)
  - 3: 0x0001C ← 1 (dcache mode)
  - 4: 0x00020 ← `did_p`, zero-extended
  - 5: 0x00008 ← 0 (unfreeze)
- FSM states: `e_idle`, `e_send`, `e_wait_ack`, `e_done`, `e_error`.
  - `e_idle` → `e_send`, index 0, on `start_i`.
  - `e_send` drives `cfg_v_o=1` with the registered addr/data for the current index. On transfer, go to `e_wait_ack`.
  - `e_wait_ack`: on `cfg_ack_i`, if index==5 go to `e_done`; else increment the index and go to `e_send`.
  - `e_done`: `start_i` restarts at index 0.
  - `e_error`: `start_i` restarts at index 0.
- `cfg_addr_o` and `cfg_data_o` are stable whenever `cfg_v_o=1` and change only after a transfer. `cfg_v_o` never drops before a transfer, except on timeout or reset.
- `cfg_ack_i` outside `e_wait_ack` is ignored. This includes an ack in the same cycle as a transfer.
- `start_i` in `e_send` or `e_wait_ack` is ignored.
- `busy_o` = state ∈ {`e_send`, `e_wait_ack`}.
- Zero-extension of PC and DID is to `cfg_data_width_p`. Index wrap is impossible because the counter saturates at 5.

## Timing
- All outputs are registered or decoded from registered state.
- Reset values: `cfg_v_o`=0, `cfg_addr_o`=0, `cfg_data_o`=0, `busy_o`=0, `done_o`=0, `error_o`=0, state `e_idle`, index 0.
- Reset mid-sequence takes effect asynchronously. Any outstanding write is abandoned and no ack is awaited afterward.
- `start_i` high at cycle t → `cfg_v_o`=1 at t+1.
- Transfer at cycle a → wait for ack from a+1. Ack at cycle b → next `cfg_v_o` at b+1.
- Minimum full sequence: start at t, last ack at t+12, `done_o`=1 at t+13.

## Configuration
- `BP_HB_CFG_SEQ_TIMEOUT_EN` defined:
  - A counter clears on every entry to `e_send` or `e_wait_ack` and increments each cycle in those states.
  - When the counter equals `timeout_cycles_p`-1, the next state is `e_error`: `error_o`=1, `cfg_v_o`=0, `busy_o`=0.
- Macro undefined:
  - No counter is instantiated, `error_o` is tied to 0, and `e_error` is unreachable.

## Test plan
- Ready and ack always high, start at cycle 10 → six writes with exactly the addr/data listed in Operation, `done_o` rises at cycle 23, `busy_o` high on cycles 11–22.
- `cfg_ready_i` low for 5 cycles while write 2 is pending → `cfg_v_o`, addr 0x00018 and data 1 held stable for 5 cycles, exactly one transfer, ordering unchanged.
- `start_i` pulsed during write 3 → ignored. `start_i` in `e_done` → `done_o`=0 next cycle and write 0 (0x00008 ← 1) reissued.
- `reset_i` asserted during `e_wait_ack` of write 3 → all outputs 0 immediately. A later start begins at write 0.
- `cfg_ack_i` asserted in the same cycle as the transfer of write 1, then low → FSM stays in `e_wait_ack`. A later ack advances to write 2.
- Macro defined, `timeout_cycles_p`=16, ack never asserted after write 0's transfer → `error_o`=1 and `cfg_v_o`=0 exactly 16 cycles after entering `e_wait_ack`. Macro undefined, same stimulus → `busy_o` stays 1 and `error_o` stays 0 indefinitely.
